// File: rtl/rip_axi_burst_writer.sv
// AXI4 write master: turns one (address, beat count) command plus a
// valid/ready data stream into INCR bursts. Bursts are split at
// MAX_BURST_LEN and at 4 KiB pages, and only one is outstanding at a time.
//
// Handshake rule for every valid/ready pair on this block: a transfer
// happens on a rising clk edge where valid and ready are both high; a
// master holds valid and its payload stable until that edge.
module rip_axi_burst_writer #(
  parameter int ID_WIDTH      = 4,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_BURST_LEN = 16,
  parameter int CNT_WIDTH     = 16,
  parameter logic [ID_WIDTH-1:0] AXI_ID = '0
) (
  input  logic                    clk,
  input  logic                    sys_rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   start_addr,
  input  logic [CNT_WIDTH-1:0]    num_beats,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [ID_WIDTH-1:0]     AWID,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic [7:0]              AWLEN,
  output logic                    AWVALID,
  output logic [2:0]              AWSIZE,
  output logic [1:0]              AWBURST,
  output logic                    AWLOCK,
  output logic [3:0]              AWCACHE,
  output logic [2:0]              AWPROT,
  output logic [3:0]              AWQOS,
  output logic [3:0]              AWREGION,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WLAST,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [ID_WIDTH-1:0]     BID,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,
  output logic [2:0]              dbg_state
);

  localparam int SIZE = $clog2(DATA_WIDTH / 8);
  // Working width for the burst-length minimum: wide enough for rem and
  // for a page beat count (up to 4096), always at least 14 bits.
  localparam int CW = ((CNT_WIDTH > 13) ? CNT_WIDTH : 13) + 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~((ADDR_WIDTH'(1) << SIZE) - ADDR_WIDTH'(1));

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_RESP = 3'd4,
    S_FIN  = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CNT_WIDTH-1:0]    rem_q, rem_d;
  logic [8:0]              blen_q, blen_d;
  logic [8:0]              beat_q, beat_d;
  logic                    error_q, error_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [7:0]              awlen_q, awlen_d;

  logic [12:0]   page_bytes;
  logic [CW-1:0] page_beats;
  logic [CW-1:0] rem_ext;
  logic [CW-1:0] blen_calc;
  logic          unused_ok;

  // Length of the next burst: smallest of the burst cap, the beats left and the beats left in the 4 KiB page.
  always_comb begin
    page_bytes = 13'h1000 - {1'b0, addr_q[11:0]};
    page_beats = CW'(page_bytes >> SIZE);
    rem_ext    = CW'(rem_q);
    blen_calc  = CW'(MAX_BURST_LEN);
    if (rem_ext < blen_calc) blen_calc = rem_ext;
    if (page_beats < blen_calc) blen_calc = page_beats;
  end

  // State register and datapath flops; reset abandons any AXI traffic in flight.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      blen_q   <= '0;
      beat_q   <= '0;
      error_q  <= 1'b0;
      awaddr_q <= '0;
      awlen_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      blen_q   <= blen_d;
      beat_q   <= beat_d;
      error_q  <= error_d;
      awaddr_q <= awaddr_d;
      awlen_q  <= awlen_d;
    end
  end

  // Next-state and datapath updates for the command/burst sequencer.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    blen_d   = blen_q;
    beat_d   = beat_q;
    error_d  = error_q;
    awaddr_d = awaddr_q;
    awlen_d  = awlen_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = start_addr & ALIGN_MASK;
          rem_d   = num_beats;
          error_d = 1'b0;
          state_d = (num_beats == '0) ? S_FIN : S_CALC;
        end
      end
      S_CALC: begin
        blen_d   = blen_calc[8:0];
        awaddr_d = addr_q;
        awlen_d  = 8'(blen_calc[8:0] - 9'd1);
        state_d  = S_ADDR;
      end
      S_ADDR: begin
        if (AWREADY) begin
          beat_d  = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (s_valid && WREADY) begin
          beat_d = beat_q + 9'd1;
          if (beat_q == blen_q - 9'd1) state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (BVALID) begin
          if (BRESP != 2'b00) error_d = 1'b1;
          addr_d  = addr_q + (ADDR_WIDTH'(blen_q) << SIZE);
          rem_d   = rem_q - CNT_WIDTH'(blen_q);
          state_d = (rem_q == CNT_WIDTH'(blen_q)) ? S_FIN : S_CALC;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs from the state, plus the W channel pass-through of the data stream.
  always_comb begin
    busy    = (state_q == S_CALC) || (state_q == S_ADDR) ||
              (state_q == S_DATA) || (state_q == S_RESP);
    done    = (state_q == S_FIN);
    AWVALID = (state_q == S_ADDR);
    BREADY  = (state_q == S_RESP);
    WVALID  = (state_q == S_DATA) && s_valid;
    s_ready = (state_q == S_DATA) && WREADY;
    WLAST   = (state_q == S_DATA) && (beat_q == blen_q - 9'd1);
    WDATA   = s_data;
  end

  assign error     = error_q;
  assign AWADDR    = awaddr_q;
  assign AWLEN     = awlen_q;
  assign AWID      = AXI_ID;
  assign AWSIZE    = 3'(SIZE);
  assign AWBURST   = 2'b01;
  assign AWLOCK    = 1'b0;
  assign AWCACHE   = 4'b0011;
  assign AWPROT    = 3'b000;
  assign AWQOS     = 4'b0000;
  assign AWREGION  = 4'b0000;
  assign WSTRB     = '1;
  assign dbg_state = state_q;

  // BID is deliberately ignored: a single fixed ID with one burst in flight.
  assign unused_ok = ^{BID, blen_calc[CW-1:9]};

endmodule

// File: tb/tb_rip_axi_burst_writer.sv
// Bench for rip_axi_burst_writer: a behavioural AXI slave and data source,
// with expected AW bursts and W data queued when a command is issued and
// popped as the DUT produces them.
module tb_rip_axi_burst_writer;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int CW  = 16;
  localparam int IDW = 4;

  logic            clk = 1'b0;
  logic            sys_rst;
  logic            start;
  logic [AW-1:0]   start_addr;
  logic [CW-1:0]   num_beats;
  logic            busy, done, error;
  logic [DW-1:0]   s_data;
  logic            s_valid, s_ready;
  logic [IDW-1:0]  AWID;
  logic [AW-1:0]   AWADDR;
  logic [7:0]      AWLEN;
  logic            AWVALID;
  logic [2:0]      AWSIZE;
  logic [1:0]      AWBURST;
  logic            AWLOCK;
  logic [3:0]      AWCACHE;
  logic [2:0]      AWPROT;
  logic [3:0]      AWQOS;
  logic [3:0]      AWREGION;
  logic            AWREADY;
  logic [DW-1:0]   WDATA;
  logic [DW/8-1:0] WSTRB;
  logic            WLAST, WVALID, WREADY;
  logic [IDW-1:0]  BID;
  logic [1:0]      BRESP;
  logic            BVALID, BREADY;
  logic [2:0]      dbg_state;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [39:0]   exp_aw_q[$];
  logic [DW-1:0] exp_w_q[$];
  logic [DW-1:0] src_q[$];

  // clock / reset
  always #5 clk = ~clk;

  rip_axi_burst_writer #(
    .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .MAX_BURST_LEN(16), .CNT_WIDTH(CW), .AXI_ID('0)
  ) dut (
    .clk(clk), .sys_rst(sys_rst), .start(start), .start_addr(start_addr),
    .num_beats(num_beats), .busy(busy), .done(done), .error(error),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWLOCK(AWLOCK), .AWCACHE(AWCACHE),
    .AWPROT(AWPROT), .AWQOS(AWQOS), .AWREGION(AWREGION), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .dbg_state(dbg_state)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_idle_outs(input string tag);
    check_eq({tag, "_flags"},
             64'({busy, done, error, s_ready, AWVALID, WVALID, WLAST, BREADY}), 64'(0));
    check_eq({tag, "_awaddr_awlen"}, 64'({AWADDR, AWLEN}), 64'(0));
    check_eq({tag, "_state"}, 64'(dbg_state), 64'(0));
  endtask

  task automatic clear_inputs();
    start = 1'b0; start_addr = '0; num_beats = '0;
    s_valid = 1'b0; s_data = '0;
    AWREADY = 1'b0; WREADY = 1'b0;
    BVALID = 1'b0; BRESP = 2'b00; BID = '0;
  endtask

  // Reference split of a command into bursts (16-beat cap, 4 KiB pages, 4-byte beats).
  task automatic build_exp(input logic [AW-1:0] a0, input int n);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int r, pb, bl;
    exp_aw_q.delete(); exp_w_q.delete(); src_q.delete();
    a = a0 & ~32'h3;
    r = n;
    while (r > 0) begin
      pb = (4096 - int'(a[11:0])) / 4;
      bl = 16;
      if (r < bl) bl = r;
      if (pb < bl) bl = pb;
      exp_aw_q.push_back({a, 8'(bl - 1)});
      a = a + 32'(bl * 4);
      r -= bl;
    end
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      src_q.push_back(d);
      exp_w_q.push_back(d);
    end
  endtask

  // Issue one command and act as AXI slave + data source until done.
  task automatic run_cmd(input logic [AW-1:0] a, input int n, input bit rnd,
                         input int err_burst, input int exp_bursts, input bit exp_err);
    int cycles, aw_cnt, wl_cnt, b_idx, b_pend, cur_len, beat_idx, beat_total, b_cycle;
    bit done_seen, aw_stall, s_hs, b_hs;
    logic [39:0] aw_hold, aw_exp;
    logic [DW-1:0] wexp;
    build_exp(a, n);
    cycles = 0; aw_cnt = 0; wl_cnt = 0; b_idx = 0; b_pend = 0; cur_len = 0;
    beat_idx = 0; beat_total = 0; b_cycle = -10;
    done_seen = 0; aw_stall = 0; s_hs = 0; b_hs = 0; aw_hold = '0;
    @(posedge clk); #1;
    clear_inputs();
    start = 1'b1; start_addr = a; num_beats = CW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    while (!done_seen && cycles < 3000) begin
      // drive this cycle's slave/source inputs
      AWREADY = rnd ? 1'($urandom_range(0, 3) != 0) : 1'b1;
      WREADY  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (s_hs) s_valid = 1'b0;
      if (!s_valid && src_q.size() > 0 && (!rnd || $urandom_range(0, 1) == 1)) begin
        s_valid = 1'b1;
        s_data  = src_q[0];
      end
      if (b_hs) BVALID = 1'b0;
      if (!BVALID && b_pend > 0 && (!rnd || $urandom_range(0, 2) == 0)) begin
        BVALID = 1'b1;
        BRESP  = (b_idx == err_burst) ? 2'b10 : 2'b00;
      end
      s_hs = 0; b_hs = 0;
      // sample away from the active edge
      @(negedge clk);
      if (cycles == 0 && n > 0) check_eq("busy_after_start", 64'(busy), 64'(1));
      if (done) begin
        done_seen = 1;
        if (n > 0) check_eq("done_after_b", 64'(cycles - b_cycle), 64'(1));
        else check_eq("zero_done_latency", 64'(cycles <= 1), 64'(1));
      end
      if (AWVALID) begin
        if (aw_stall) check_eq("aw_stable", 64'({AWADDR, AWLEN}), 64'(aw_hold));
        if (AWREADY) begin
          aw_cnt++;
          aw_stall = 0;
          if (exp_aw_q.size() == 0) check_eq("aw_count_ovf", 64'(aw_cnt), 64'(exp_bursts));
          else begin
            aw_exp = exp_aw_q.pop_front();
            check_eq("aw_addr_len", 64'({AWADDR, AWLEN}), 64'(aw_exp));
            cur_len  = int'(aw_exp[7:0]) + 1;
            beat_idx = 0;
          end
        end else begin
          aw_stall = 1;
          aw_hold  = {AWADDR, AWLEN};
        end
      end
      if (WVALID && WREADY) begin
        beat_total++;
        if (exp_w_q.size() == 0) check_eq("w_beat_ovf", 64'(beat_total), 64'(n));
        else begin
          wexp = exp_w_q.pop_front();
          check_eq("wdata", 64'(WDATA), 64'(wexp));
        end
        check_eq("wlast", 64'(WLAST), 64'(beat_idx == cur_len - 1));
        if (WLAST) begin wl_cnt++; b_pend++; end
        beat_idx++;
        s_hs = 1;
        if (src_q.size() > 0) void'(src_q.pop_front());
      end
      if (BVALID && BREADY) begin
        b_hs = 1; b_pend--; b_idx++; b_cycle = cycles;
      end
      if (!done_seen) begin
        @(posedge clk); #1;
        cycles++;
      end
    end
    check_eq("done_timeout", 64'(done_seen), 64'(1));
    check_eq("error_at_done", 64'(error), 64'(exp_err));
    check_eq("aw_count", 64'(aw_cnt), 64'(exp_bursts));
    check_eq("wlast_count", 64'(wl_cnt), 64'(exp_bursts));
    check_eq("beat_count", 64'(beat_total), 64'(n));
    check_eq("w_queue_left", 64'(exp_w_q.size()), 64'(0));
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    check_eq("done_one_cycle", 64'({done, busy}), 64'(0));
    check_eq("error_sticky", 64'(error), 64'(exp_err));
  endtask

  // Start a long command, reset it partway through the data phase.
  task automatic reset_mid_burst();
    int beats;
    beats = 0;
    build_exp(32'h500, 20);
    @(posedge clk); #1;
    clear_inputs();
    start = 1'b1; start_addr = 32'h500; num_beats = 16'd20;
    @(posedge clk); #1;
    start = 1'b0; AWREADY = 1'b1; WREADY = 1'b1;
    s_valid = 1'b1; s_data = 32'hA5A5_0000;
    for (int c = 0; c < 50 && beats < 3; c++) begin
      @(negedge clk);
      if (WVALID && WREADY) beats++;
      @(posedge clk); #1;
      s_data = s_data + 32'd1;
    end
    check_eq("rst_reached_data", 64'(beats), 64'(3));
    sys_rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_idle_outs("mid_rst");
    @(posedge clk); #1;
    sys_rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    sys_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_idle_outs("reset");
    check_eq("aw_consts",
             64'({AWID, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION, WSTRB}),
             64'({4'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0, 4'd0, 4'hF}));
    @(posedge clk); #1;
    sys_rst = 1'b0;

    run_cmd(32'h0000_1000, 4,  1'b0, -1, 1, 1'b0);
    run_cmd(32'h0000_0000, 40, 1'b0, -1, 3, 1'b0);
    run_cmd(32'h0000_0FF8, 8,  1'b0, -1, 2, 1'b0);
    run_cmd(32'h0000_1F00, 70, 1'b1, -1, 5, 1'b0);
    run_cmd(32'h0000_0FE6, 23, 1'b1, -1, 2, 1'b0);
    run_cmd(32'h0000_0000, 40, 1'b0,  1, 3, 1'b1);
    run_cmd(32'h0000_0200, 0,  1'b0, -1, 0, 1'b0);
    reset_mid_burst();
    run_cmd(32'h0000_3000, 20, 1'b1, -1, 2, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
